// File: rtl/core_task_scheduler_pkg.sv
// core_sched_pkg: shared FSM state type, mode encodings and default sizes for the task scheduler
package core_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN, ST_DONE} state_t;
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_ALL   = 2'b01;
  localparam logic [1:0] MODE_CORE0 = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;
  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_TASK_W = 8;
endpackage

// File: rtl/core_task_scheduler_if.sv
// core_sched_if: scheduler <-> core array signals (task dispatch, completion, shared memory arbitration)
interface core_sched_if
  import core_sched_pkg::*;
#(parameter int NUM_CORES = DEF_NUM_CORES, parameter int TASK_W = DEF_TASK_W);
  logic [NUM_CORES-1:0] core_start, end_process, mem_req, mem_gnt;
  logic [NUM_CORES*TASK_W-1:0] core_task;
  modport master (output core_start, core_task, mem_gnt, input end_process, mem_req);
  modport slave (input core_start, core_task, mem_gnt, output end_process, mem_req);
endinterface

// File: rtl/core_task_scheduler_rr_arbiter.sv
// rr_arbiter: registered round-robin grant of one shared port, locked while the owner keeps requesting
module rr_arbiter #(parameter int NUM_CORES = 4) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_CORES-1:0] active,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] gnt
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic hit;
  // release on owner drop (one idle cycle, pointer past owner), otherwise search from pointer
  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    idx = '0;
    hit = 1'b0;
    if (ena && |gnt_q && !(|(gnt_q & req & active))) begin
      gnt_d = '0;
      for (int i = 0; i < NUM_CORES; i++)
        if (gnt_q[i]) ptr_d = (i == NUM_CORES - 1) ? '0 : PW'(i + 1);
    end else if (ena && !(|gnt_q)) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        idx = PW'((int'(ptr_q) + k) % NUM_CORES);
        if (!hit && req[idx] && active[idx]) begin
          gnt_d[idx] = 1'b1;
          hit = 1'b1;
        end
      end
    end
  end
  // grant and pointer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  assign gnt = gnt_q;
endmodule

// File: rtl/core_task_scheduler.sv
// core_task_scheduler: dispatches job tasks to cores, tracks completion, pulses z; optional watchdog via CORE_SCHED_TIMEOUT_EN
module core_task_scheduler
  import core_sched_pkg::*;
#(
  parameter int NUM_CORES   = DEF_NUM_CORES,
  parameter int TASK_W      = DEF_TASK_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [1:0]           status,
  input  logic                 start,
  input  logic [TASK_W-1:0]    num_tasks,
  core_sched_if.master         cif,
  output logic                 busy,
  output logic                 z,
  output logic [NUM_CORES-1:0] timeout_err
);
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [TASK_W-1:0] num_q, num_d;
  logic [TASK_W:0] next_q, next_d;
  logic [NUM_CORES-1:0] cbusy_q, cbusy_d, start_q, start_d, active, free;
  logic [NUM_CORES*TASK_W-1:0] task_q, task_d;
  logic busy_q, busy_d, z_q, z_d, accept, hit;
`ifdef CORE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q [NUM_CORES];
  logic [CW-1:0] cnt_d [NUM_CORES];
  logic [NUM_CORES-1:0] err_q, err_d;
  assign timeout_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_err = '0;
`endif
  assign active = (mode_q == MODE_ALL) ? '1 : (mode_q == MODE_CORE0) ? NUM_CORES'(1) : '0;
  assign free = active & ~cbusy_q;
  assign accept = (state_q == ST_IDLE) && ena && start && (status == MODE_ALL || status == MODE_CORE0);
  // next-state: job accept, one dispatch per cycle to the lowest free core, drain, completion pulse
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    num_d = num_q;
    next_d = next_q;
    cbusy_d = cbusy_q & ~cif.end_process;
    start_d = '0;
    task_d = task_q;
    busy_d = busy_q;
    z_d = 1'b0;
    hit = 1'b0;
    if (accept) begin
      mode_d = status;
      num_d = num_tasks;
      next_d = '0;
      busy_d = 1'b1;
      state_d = (num_tasks == '0) ? ST_DONE : ST_DISPATCH;
    end
    if (ena && state_q == ST_DISPATCH) begin
      for (int i = 0; i < NUM_CORES; i++)
        if (!hit && free[i]) begin
          hit = 1'b1;
          start_d[i] = 1'b1;
          task_d[i*TASK_W +: TASK_W] = next_q[TASK_W-1:0];
          cbusy_d[i] = 1'b1;
        end
      if (hit) next_d = next_q + 1'b1;
      if (hit && next_d == {1'b0, num_q}) state_d = ST_DRAIN;
    end
    if (ena && state_q == ST_DRAIN && cbusy_q == '0) state_d = ST_DONE;
    if (ena && state_q == ST_DONE) begin
      z_d = 1'b1;
      busy_d = 1'b0;
      state_d = ST_IDLE;
    end
`ifdef CORE_SCHED_TIMEOUT_EN
    err_d = accept ? '0 : err_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      cnt_d[i] = start_d[i] ? '0 : cbusy_q[i] ? cnt_q[i] + 1'b1 : '0;
      if (cbusy_q[i] && cnt_q[i] == CW'(TIMEOUT_CYC - 1)) begin
        err_d[i] = 1'b1;
        cbusy_d[i] = 1'b0;
      end
    end
`endif
  end
  // all scheduler state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q <= MODE_IDLE;
      num_q <= '0;
      next_q <= '0;
      cbusy_q <= '0;
      start_q <= '0;
      task_q <= '0;
      busy_q <= 1'b0;
      z_q <= 1'b0;
`ifdef CORE_SCHED_TIMEOUT_EN
      cnt_q <= '{default: '0};
      err_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      num_q <= num_d;
      next_q <= next_d;
      cbusy_q <= cbusy_d;
      start_q <= start_d;
      task_q <= task_d;
      busy_q <= busy_d;
      z_q <= z_d;
`ifdef CORE_SCHED_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clk(clk), .rst_n(rst_n), .ena(ena), .active(active), .req(cif.mem_req), .gnt(cif.mem_gnt)
  );
  assign cif.core_start = start_q;
  assign cif.core_task = task_q;
  assign busy = busy_q;
  assign z = z_q;
endmodule

// File: tb/tb_core_task_scheduler.sv
// tb_core_task_scheduler: directed scoreboard bench for core_task_scheduler (timeout case under CORE_SCHED_TIMEOUT_EN)
module tb_core_task_scheduler;
  import core_sched_pkg::*;
  localparam int NC = 4;
  localparam int TW = 8;
  typedef struct {int core; int tsk;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0;
  logic [1:0] status = 2'b00;
  logic [TW-1:0] num_tasks = '0;
  logic busy, z;
  logic [NC-1:0] timeout_err;
  logic [NC-1:0] never_end = '0;
  int compared = 0, mismatched = 0;
  exp_t exp_q[$];
  core_sched_if #(.NUM_CORES(NC), .TASK_W(TW)) cif();
  core_task_scheduler #(.NUM_CORES(NC), .TASK_W(TW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .status(status), .start(start), .num_tasks(num_tasks),
    .cif(cif), .busy(busy), .z(z), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int t);
    exp_t e;
    e.core = c;
    e.tsk = t;
    exp_q.push_back(e);
  endtask

  // called at a falling edge; start is seen by the next rising edge
  task automatic drive_start(input logic [1:0] st, input int n);
    status = st;
    num_tasks = TW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_z(input string tag, input int budget);
    int n = 0;
    while (z !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_z_seen"}, z, 1);
    check({tag, "_busy_low"}, busy, 0);
    @(negedge clk);
    check({tag, "_z_single"}, z, 0);
  endtask

  // core model: each started core ends 5 cycles later unless masked in never_end
  initial begin
    int cnt[NC];
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    cif.end_process = '0;
    forever begin
      @(negedge clk);
      cif.end_process = '0;
      for (int i = 0; i < NC; i++) begin
        if (!rst_n) cnt[i] = 0;
        else begin
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) cif.end_process[i] = 1'b1;
          end
          if (cif.core_start[i] && !never_end[i]) cnt[i] = 5;
        end
      end
    end
  end

  // monitor: grant never has two bits; every core_start is matched against the scoreboard
  initial begin
    exp_t e;
    logic [NC-1:0] v;
    forever begin
      @(negedge clk);
      check("gnt_onehot0", 64'($onehot0(cif.mem_gnt)), 64'd1);
      if (|cif.core_start) begin
        if (exp_q.size() == 0) check("unexpected_start", 64'(cif.core_start), 64'd0);
        else begin
          e = exp_q.pop_front();
          v = NC'(1) << e.core;
          check("start_vec", 64'(cif.core_start), 64'(v));
          check("start_task", 64'(cif.core_task[e.core*TW +: TW]), 64'(e.tsk));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NC-1:0] ev;
    cif.mem_req = '0;
    repeat (2) @(negedge clk);
    check("rst_core_start", cif.core_start, 0);
    check("rst_core_task", cif.core_task, 0);
    check("rst_mem_gnt", cif.mem_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_z", z, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    drive_start(MODE_RSVD, 3);
    check("rsvd_ignored", busy, 0);
    ena = 1'b0;
    drive_start(MODE_ALL, 3);
    check("ena0_ignored", busy, 0);
    ena = 1'b1;
    for (int t = 0; t < 4; t++) push(t, t);
    push(0, 4);
    push(1, 5);
    drive_start(MODE_ALL, 6);
    check("job1_busy", busy, 1);
    wait_z("job1", 100);
    check("job1_sb_empty", exp_q.size(), 0);
    cif.mem_req = '1;
    repeat (3) begin
      @(negedge clk);
      check("arb_lock", cif.mem_gnt, 4'b0001);
    end
    for (int k = 0; k < NC; k++) begin
      cif.mem_req = 4'b1111 & ~(4'b0001 << k);
      @(negedge clk);
      check("arb_drop", cif.mem_gnt, 0);
      cif.mem_req = '1;
      @(negedge clk);
      ev = NC'(1) << ((k + 1) % NC);
      check("arb_next", cif.mem_gnt, ev);
    end
    cif.mem_req = '0;
    @(negedge clk);
    check("arb_release", cif.mem_gnt, 0);
    for (int t = 0; t < 3; t++) push(0, t);
    drive_start(MODE_CORE0, 3);
    cif.mem_req = 4'b1110;
    repeat (2) @(negedge clk);
    check("inactive_no_gnt", cif.mem_gnt, 0);
    wait_z("core0", 100);
    cif.mem_req = '0;
    check("core0_sb_empty", exp_q.size(), 0);
    check("core0_no_timeout", timeout_err, 0);
    drive_start(MODE_ALL, 0);
    check("zero_z_early", z, 0);
    check("zero_busy", busy, 1);
    @(negedge clk);
    check("zero_z", z, 1);
    check("zero_busy_low", busy, 0);
    @(negedge clk);
    check("zero_z_single", z, 0);
    push(0, 0);
    push(1, 1);
    cif.mem_req = 4'b0001;
    drive_start(MODE_ALL, 6);
    repeat (2) @(negedge clk);
    check("pre_rst_gnt", cif.mem_gnt, 4'b0001);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_core_start", cif.core_start, 0);
    check("mid_rst_core_task", cif.core_task, 0);
    check("mid_rst_gnt", cif.mem_gnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sb", exp_q.size(), 0);
    cif.mem_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) push(t, t);
    push(0, 4);
    push(1, 5);
    drive_start(MODE_ALL, 6);
    wait_z("restart", 100);
    check("restart_sb_empty", exp_q.size(), 0);
`ifdef CORE_SCHED_TIMEOUT_EN
    never_end = 4'b0100;
    for (int t = 0; t < 4; t++) push(t, t);
    drive_start(MODE_ALL, 4);
    wait_z("tmo", 200);
    check("tmo_err", timeout_err, 4'b0100);
    check("tmo_sb_empty", exp_q.size(), 0);
    never_end = '0;
    drive_start(MODE_ALL, 0);
    check("tmo_err_cleared", timeout_err, 0);
    wait_z("tmo_clr", 10);
`else
    check("tmo_tied_zero", timeout_err, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/core_task_scheduler.md
Name: core_task_scheduler

Overview:
Sequences the multi-core processing array: hands task indices to up to 4 processing cores, tracks per-core completion (end_process), and raises z once every task is finished. Also round-robin arbitrates the single shared data-memory port between the cores' requests. Sits between the top-level control inputs (status, ena) and the core array / memory enables.

Parameters:
NUM_CORES, 4, number of cores managed (2..8)
TASK_W, 8, width of task index and task count
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes dispatch and arbitration
status  input  2  mode: 00 idle, 01 all-core run, 10 core-0-only run, 11 reserved (treated as idle)
start  input  1  single-cycle pulse that begins a job
num_tasks  input  TASK_W  total tasks in the job, sampled on start
core_start  output  NUM_CORES  one-cycle pulse to a core carrying a new task
core_task  output  NUM_CORES*TASK_W  task index per core, slice i belongs to core i; held until the next dispatch to that core
end_process  input  NUM_CORES  per-core one-cycle completion pulse
mem_req  input  NUM_CORES  per-core shared-memory request, level
mem_gnt  output  NUM_CORES  one-hot or zero grant
busy  output  1  high from accepted start until z
z  output  1  one-cycle job-complete pulse
timeout_err  output  NUM_CORES  sticky per-core watchdog flag (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-job): state IDLE; core_start, core_task, mem_gnt, busy, z, timeout_err, next_task, core_busy mask and RR pointer all 0.
- Active mask: 01 -> all cores; 10 -> core 0 only; 00/11 -> none.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
- IDLE: start with ena=1 and a valid mode -> latch num_tasks and mode, busy=1. If num_tasks=0 -> DONE, else -> DISPATCH. start is ignored in any other state, with ena=0, or with an invalid mode.
- DISPATCH: each cycle with ena=1, the lowest-index free active core gets the next task:
  - core_start[i]=1 for one cycle, core_task slice i = next_task, core_busy[i] set, next_task incremented.
  - At most one dispatch per cycle.
  - When next_task reaches num_tasks -> DRAIN.
- DRAIN: wait until core_busy == 0 -> DONE.
- DONE: z=1 for exactly one cycle, busy=0 -> IDLE.
- end_process[i] clears core_busy[i] in every state. A pulse from a non-busy core is ignored.
- end_process[i] in the same cycle a dispatch decision is made: core i is seen free no earlier than the next cycle, giving a minimum 1-cycle gap between end and the next core_start.
- Mode is latched at start. A status change mid-job has no effect until the next start.
- ena=0: no dispatch, no new grant, existing grant held, FSM holds state, end_process still recorded.
- Dispatch latency: start -> first core_start is 2 cycles (start sampled, then DISPATCH).
- Arbiter:
  - Registered grant; req -> gnt latency 1 cycle.
  - Grant is locked while the owner's mem_req stays high.
  - When the owner drops its request, the grant goes to 0 for that cycle and the pointer moves to owner+1.
  - Search is round-robin from the pointer with wrap-around at NUM_CORES-1 -> 0.
  - A request from an inactive core is never granted.
- next_task width is TASK_W+1 internally so that num_tasks = 2^TASK_W-1 terminates without wrapping.

Optional Feature:
Macro CORE_SCHED_TIMEOUT_EN.
- Defined: each busy core has a counter that is cleared on dispatch. Reaching TIMEOUT_CYC sets timeout_err[i] (sticky until the next accepted start) and force-clears core_busy[i], so the job still completes with z.
- Undefined: no counters are built; timeout_err is tied to 0.

Decomposition:
- Package core_sched_pkg holds:
  - the FSM state enum
  - mode constants MODE_IDLE, MODE_ALL, MODE_CORE0, MODE_RSVD
  - the default NUM_CORES and TASK_W localparams
- Sub-module: rr_arbiter (parameterised NUM_CORES, locked round-robin grant). The FSM stays in core_task_scheduler.

Test Plan:
- status=01, start, num_tasks=6, each core pulses end_process 5 cycles after its core_start -> tasks 0..3 go to cores 0..3 on consecutive cycles, then tasks 4 and 5 follow end pulses; a single z pulse and busy falls with it.
- status=10, num_tasks=3 -> only core 0 is ever started with tasks 0,1,2; core_start[3:1] stay 0.
- num_tasks=0 with start -> z pulses 2 cycles after start; core_start never asserts.
- mem_req=1111 held for 3 cycles, then the owner drops each in turn -> grants go 0001, 0010, 0100, 1000, then wrap to 0001; never two bits set.
- rst_n low mid-DISPATCH, then start without a reset cycle -> all outputs 0 immediately, and a fresh start restarts from task 0.
- CORE_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, core 2 never ends -> timeout_err=0100 after 16 cycles and z still asserts.
